// File: rtl/ram_stream_reader_pkg.sv
// Shared constants and FSM state encoding for the RAM stream reader.
// Default geometry is the 8-bit x 256-word RAM the reader is normally paired with.
package ram_stream_reader_pkg;

   localparam int RSR_RAM_WIDTH = 8;
   localparam int RSR_RAM_DEPTH = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } rsr_state_t;

endpackage

// File: rtl/ram_stream_reader_skid_buf.sv
// Two-entry FIFO between the RAM read pipeline and the stream output.
// The head entry stays put until it is accepted, so dout is stable while stalled.
module stream_skid_buf #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             valid,
   input  logic             ready,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = (r_count != 2'd0) && ready;
   assign w_push = push && ((r_count != 2'd2) || w_pop);

   // NOTE: the two storage words are reset so that the stream data output
   // reads zero after reset instead of leftover data from an aborted burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         if (w_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign valid = (r_count != 2'd0);
   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of consecutive words from a synchronous single-port RAM and
// presents them as a valid/ready stream with a last-beat marker and done pulse.
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter  int RAM_WIDTH = RSR_RAM_WIDTH,
   parameter  int RAM_DEPTH = RSR_RAM_DEPTH,
   localparam int ADDR_W    = $clog2(RAM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W:0]      length,
   output logic                 ram_we,
   output logic [ADDR_W-1:0]    ram_addr,
   input  logic [RAM_WIDTH-1:0] ram_dout,
   output logic                 m_valid,
   output logic [RAM_WIDTH-1:0] m_data,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 done
);

   localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(RAM_DEPTH - 1);

   rsr_state_t          r_state;
   rsr_state_t          w_state_nxt;
   logic [ADDR_W-1:0]   r_next_addr;
   logic [ADDR_W-1:0]   r_addr_hold;
   logic [ADDR_W-1:0]   w_addr_inc;
   logic [ADDR_W:0]     r_remain;
   logic                r_rd_vld;
   logic                r_rd_last;
   logic                r_done;
   logic                w_issue;
   logic                w_xfer;
   logic                w_final_xfer;
   logic                w_zero_start;
   logic                w_buf_valid;
   logic [1:0]          w_buf_count;
   logic [RAM_WIDTH:0]  w_buf_dout;

   // Each buffer entry carries its last-beat flag alongside the data word.
   stream_skid_buf #(
      .WIDTH (RAM_WIDTH + 1)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (r_rd_vld),
      .din   ({r_rd_last, ram_dout}),
      .valid (w_buf_valid),
      .ready (m_ready),
      .dout  (w_buf_dout),
      .count (w_buf_count)
   );

   assign w_xfer       = w_buf_valid && m_ready;
   assign w_final_xfer = w_xfer && w_buf_dout[RAM_WIDTH];
   assign w_zero_start = (r_state == ST_IDLE) && start && (length == '0);
   assign w_addr_inc   = (r_next_addr == ADDR_TOP) ? '0 : r_next_addr + 1'b1;

   always_comb begin
      // NOTE: defaults first so no path through the case leaves an output
      // unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && (length != '0)) begin
               w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            // Issue only if buffered + in-flight words, net of this cycle's
            // transfer, leave room for one more.
            if (({1'b0, w_buf_count} + {2'b00, r_rd_vld}) < (3'd2 + {2'b00, w_xfer})) begin
               w_issue = 1'b1;
               if (r_remain == LEN_ONE) begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (w_final_xfer) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_next_addr <= '0;
         r_addr_hold <= '0;
         r_remain    <= '0;
         r_rd_vld    <= 1'b0;
         r_rd_last   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_vld  <= w_issue;
         r_rd_last <= w_issue && (r_remain == LEN_ONE);
         r_done    <= w_zero_start || ((r_state == ST_DRAIN) && w_final_xfer);
         if ((r_state == ST_IDLE) && start) begin
            r_next_addr <= base_addr;
            r_remain    <= length;
         end else if (w_issue) begin
            r_next_addr <= w_addr_inc;
            r_remain    <= r_remain - LEN_ONE;
            r_addr_hold <= r_next_addr;
         end
      end
   end

   assign ram_we   = 1'b0;
   assign ram_addr = w_issue ? r_next_addr : r_addr_hold;
   assign m_valid  = w_buf_valid;
   assign m_data   = w_buf_dout[RAM_WIDTH-1:0];
   assign m_last   = w_buf_valid && w_buf_dout[RAM_WIDTH];
   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;

endmodule
